// File: rtl/csi2_pkg.sv
// Shared constants, FSM encoding and header ECC helper for the CSI-2 packet layer.
package csi2_pkg;

  localparam logic [5:0]  DT_FS        = 6'h00;
  localparam logic [5:0]  DT_FE        = 6'h01;
  localparam logic [5:0]  DT_LS        = 6'h02;
  localparam logic [5:0]  DT_LE        = 6'h03;
  localparam logic [5:0]  DT_SHORT_MAX = 6'h0F;

  localparam logic [15:0] CRC_SEED   = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_R = 16'h8408;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CRC,
    ST_DONE
  } state_e;

  // Each parity bit covers a fixed subset of D[23:0] = {WC MSB, WC LSB, DI}
  function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

endpackage

// File: rtl/csi2_crc16.sv
// Byte-wide reflected CRC-16 (x^16+x^12+x^5+1), LSB-first; init has priority over en.
module csi2_crc16
  import csi2_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_SEED;
    end else if (en_i) begin
      crc_d = crc_q ^ {8'h00, data_i};
      for (int i = 0; i < 8; i++)
        crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC_POLY_R) : (crc_d >> 1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/csi2_packet_parser.sv
// CSI-2 packet layer: header decode with ECC check, short/long split, payload forward with CRC-16 check.
module csi2_packet_parser
  import csi2_pkg::*;
#(
  parameter logic [15:0] MAX_WC = 16'd4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hs_mode,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        hdr_valid,
  output logic [7:0]  pkt_di,
  output logic [15:0] pkt_wc,
  output logic        short_pkt,
  output logic        fs,
  output logic        fe,
  output logic        ls,
  output logic        le,
  output logic        pay_valid,
  output logic [7:0]  pay_data,
  output logic        pay_last,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        ecc_err,
  output logic        len_err
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  di_q, di_d;
  logic [15:0] wc_q, wc_d;
  logic [7:0]  crcl_q, crcl_d;

  logic        hdr_valid_q, hdr_valid_d, short_q, short_d;
  logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic [7:0]  pkt_di_q, pkt_di_d, pay_data_q, pay_data_d;
  logic [15:0] pkt_wc_q, pkt_wc_d;
  logic        pay_valid_q, pay_valid_d, pay_last_q, pay_last_d;
  logic        crc_ok_q, crc_ok_d, crc_err_q, crc_err_d;
  logic        ecc_err_q, ecc_err_d, len_err_q, len_err_d;

  logic        crc_init, crc_en;
  logic [15:0] crc_val;
  logic [5:0]  dt;

  assign dt = di_q[5:0];

  csi2_crc16 u_crc (
    .clk    (clk),
    .rstn   (rstn),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (byte_in),
    .crc_o  (crc_val)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    di_d        = di_q;
    wc_d        = wc_q;
    crcl_d      = crcl_q;
    hdr_valid_d = 1'b0;
    short_d     = 1'b0;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    ls_d        = 1'b0;
    le_d        = 1'b0;
    pkt_di_d    = pkt_di_q;
    pkt_wc_d    = pkt_wc_q;
    pay_valid_d = 1'b0;
    pay_data_d  = pay_data_q;
    pay_last_d  = 1'b0;
    crc_ok_d    = 1'b0;
    crc_err_d   = 1'b0;
    ecc_err_d   = 1'b0;
    len_err_d   = 1'b0;
    crc_init    = 1'b0;
    crc_en      = 1'b0;

    if (!hs_mode) begin
      // EoT before the packet completed is a length error; trailer EoT is silent
      if (state_q inside {ST_HDR, ST_PAYLOAD, ST_CRC}) len_err_d = 1'b1;
      state_d = ST_IDLE;
    end else if (byte_en) begin
      case (state_q)
        ST_IDLE: begin
          di_d    = byte_in;
          cnt_d   = 2'd0;
          state_d = ST_HDR;
        end
        ST_HDR: begin
          if (cnt_q == 2'd0) begin
            wc_d  = {wc_q[15:8], byte_in};
            cnt_d = 2'd1;
          end else if (cnt_q == 2'd1) begin
            wc_d  = {byte_in, wc_q[7:0]};
            cnt_d = 2'd2;
          end else begin
            hdr_valid_d = 1'b1;
            pkt_di_d    = di_q;
            pkt_wc_d    = wc_q;
            short_d     = (dt <= DT_SHORT_MAX);
            fs_d        = (dt == DT_FS);
            fe_d        = (dt == DT_FE);
            ls_d        = (dt == DT_LS);
            le_d        = (dt == DT_LE);
            ecc_err_d   = (csi2_ecc({wc_q, di_q}) != byte_in[5:0]) || (byte_in[7:6] != 2'b00);
            cnt_d       = 2'd0;
            if (dt <= DT_SHORT_MAX) begin
              state_d = ST_DONE;
            end else if (wc_q > MAX_WC) begin
              len_err_d = 1'b1;
              state_d   = ST_DONE;
            end else begin
              crc_init = 1'b1;
              state_d  = (wc_q == 16'd0) ? ST_CRC : ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          pay_valid_d = 1'b1;
          pay_data_d  = byte_in;
          crc_en      = 1'b1;
          wc_d        = wc_q - 16'd1;
          if (wc_q == 16'd1) begin
            pay_last_d = 1'b1;
            cnt_d      = 2'd0;
            state_d    = ST_CRC;
          end
        end
        ST_CRC: begin
          if (cnt_q == 2'd0) begin
            crcl_d = byte_in;
            cnt_d  = 2'd1;
          end else begin
            crc_ok_d  = ({byte_in, crcl_q} == crc_val);
            crc_err_d = ({byte_in, crcl_q} != crc_val);
            state_d   = ST_DONE;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      di_q        <= '0;
      wc_q        <= '0;
      crcl_q      <= '0;
      hdr_valid_q <= 1'b0;
      short_q     <= 1'b0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      ls_q        <= 1'b0;
      le_q        <= 1'b0;
      pkt_di_q    <= '0;
      pkt_wc_q    <= '0;
      pay_valid_q <= 1'b0;
      pay_data_q  <= '0;
      pay_last_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      ecc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      di_q        <= di_d;
      wc_q        <= wc_d;
      crcl_q      <= crcl_d;
      hdr_valid_q <= hdr_valid_d;
      short_q     <= short_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      ls_q        <= ls_d;
      le_q        <= le_d;
      pkt_di_q    <= pkt_di_d;
      pkt_wc_q    <= pkt_wc_d;
      pay_valid_q <= pay_valid_d;
      pay_data_q  <= pay_data_d;
      pay_last_q  <= pay_last_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      ecc_err_q   <= ecc_err_d;
      len_err_q   <= len_err_d;
    end
  end

  assign hdr_valid = hdr_valid_q;
  assign pkt_di    = pkt_di_q;
  assign pkt_wc    = pkt_wc_q;
  assign short_pkt = short_q;
  assign fs        = fs_q;
  assign fe        = fe_q;
  assign ls        = ls_q;
  assign le        = le_q;
  assign pay_valid = pay_valid_q;
  assign pay_data  = pay_data_q;
  assign pay_last  = pay_last_q;
  assign crc_ok    = crc_ok_q;
  assign crc_err   = crc_err_q;
  assign ecc_err   = ecc_err_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Randomized and directed bench for csi2_packet_parser against a packet-level reference model.
module tb_csi2_packet_parser;

  localparam int MAXW = 4096;

  // Hamming column code of each header data bit D0..D23
  localparam logic [23:0][5:0] ECC_COL = {
    6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32, 6'h31,
    6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
    6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07};

  localparam int C_HV = 0, C_SP = 1, C_FS = 2, C_EE = 3, C_LEN = 4,
                 C_PV = 5, C_PL = 6, C_OK = 7, C_ERR = 8;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic        hv;
    logic [7:0]  di;
    logic [15:0] wc;
    logic        sp, fs, fe, ls, le, ee, lerr;
    logic        pv;
    logic [7:0]  pd;
    logic        pl, ok, er;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        hs_mode = 1'b0;
  logic        byte_en = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        hdr_valid, short_pkt, fs, fe, ls, le;
  logic [7:0]  pkt_di, pay_data;
  logic [15:0] pkt_wc;
  logic        pay_valid, pay_last, crc_ok, crc_err, ecc_err, len_err;

  exp_t        exp_next = '0;
  exp_t        exp_cur  = '0;
  logic [7:0]  hold_di = 8'h00;
  logic [15:0] hold_wc = 16'h0000;
  bit          chk_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cnt[9];
  int          base[9];
  logic [7:0]  last_pl_data = 8'h00;

  always #5 clk = ~clk;

  csi2_packet_parser #(.MAX_WC(16'd4096)) dut (
    .clk(clk), .rstn(rstn), .hs_mode(hs_mode), .byte_en(byte_en), .byte_in(byte_in),
    .hdr_valid(hdr_valid), .pkt_di(pkt_di), .pkt_wc(pkt_wc), .short_pkt(short_pkt),
    .fs(fs), .fe(fe), .ls(ls), .le(le),
    .pay_valid(pay_valid), .pay_data(pay_data), .pay_last(pay_last),
    .crc_ok(crc_ok), .crc_err(crc_err), .ecc_err(ecc_err), .len_err(len_err));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [5:0] ecc_model(input logic [23:0] d);
    logic [5:0] e = 6'h00;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_COL[i];
    return e;
  endfunction

  function automatic logic [15:0] crc_model(input bq_t d);
    logic [15:0] c = 16'hFFFF;
    logic [7:0]  b;
    logic        fb;
    foreach (d[i]) begin
      b = d[i];
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c  = c >> 1;
        if (fb) c ^= 16'h8408;
      end
    end
    return c;
  endfunction

  function automatic exp_t idle_e();
    exp_t e = '0;
    e.di = hold_di;
    e.wc = hold_wc;
    return e;
  endfunction

  always @(posedge clk) exp_cur <= exp_next;

  // Per-cycle comparison and event counting
  always @(negedge clk) begin
    if (hdr_valid) cnt[C_HV]++;
    if (hdr_valid && short_pkt) cnt[C_SP]++;
    if (fs) cnt[C_FS]++;
    if (ecc_err) cnt[C_EE]++;
    if (len_err) cnt[C_LEN]++;
    if (pay_valid) cnt[C_PV]++;
    if (pay_last) begin cnt[C_PL]++; last_pl_data = pay_data; end
    if (crc_ok) cnt[C_OK]++;
    if (crc_err) cnt[C_ERR]++;
    if (chk_en) begin
      chk("hdr_valid", 64'(hdr_valid), 64'(exp_cur.hv));
      chk("pkt_di", 64'(pkt_di), 64'(exp_cur.di));
      chk("pkt_wc", 64'(pkt_wc), 64'(exp_cur.wc));
      if (exp_cur.hv) chk("short_pkt", 64'(short_pkt), 64'(exp_cur.sp));
      chk("fs_fe_ls_le", 64'({fs, fe, ls, le}), 64'({exp_cur.fs, exp_cur.fe, exp_cur.ls, exp_cur.le}));
      chk("ecc_err", 64'(ecc_err), 64'(exp_cur.ee));
      chk("len_err", 64'(len_err), 64'(exp_cur.lerr));
      chk("pay_valid", 64'(pay_valid), 64'(exp_cur.pv));
      if (exp_cur.pv) chk("pay_data", 64'(pay_data), 64'(exp_cur.pd));
      chk("pay_last", 64'(pay_last), 64'(exp_cur.pl));
      chk("crc_ok", 64'(crc_ok), 64'(exp_cur.ok));
      chk("crc_err", 64'(crc_err), 64'(exp_cur.er));
    end
  end

  task automatic tick(input logic hs, input logic en, input logic [7:0] b, input exp_t e);
    @(posedge clk);
    #1;
    hs_mode  = hs;
    byte_en  = en;
    byte_in  = b;
    exp_next = e;
  endtask

  task automatic snap();
    for (int k = 0; k < 9; k++) base[k] = cnt[k];
  endtask

  function automatic int dlt(input int k);
    return cnt[k] - base[k];
  endfunction

  // Drive the first n bytes of a burst; the model derives each byte's role from its index
  task automatic send_pkt(input bq_t b, input int n, input int gap_pct, input bit skip_eot);
    logic [7:0]  di, eccb;
    logic [15:0] wc, crc;
    bit          sp, over, lng;
    int          pend;
    bq_t         pay;
    exp_t        e;
    di   = b[0];
    wc   = {b[2], b[1]};
    eccb = b[3];
    sp   = (di[5:0] <= 6'h0F);
    over = !sp && (int'(wc) > MAXW);
    lng  = !sp && !over;
    pend = lng ? 5 + int'(wc) : 3;
    pay  = {};
    if (lng) for (int i = 0; i < int'(wc); i++) pay.push_back(b[4 + i]);
    crc = crc_model(pay);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < gap_pct) tick(1'b1, 1'b0, 8'($urandom), idle_e());
      e = idle_e();
      if (i == 3) begin
        hold_di = di;
        hold_wc = wc;
        e = idle_e();
        e.hv   = 1'b1;
        e.sp   = sp;
        e.fs   = (di[5:0] == 6'h00);
        e.fe   = (di[5:0] == 6'h01);
        e.ls   = (di[5:0] == 6'h02);
        e.le   = (di[5:0] == 6'h03);
        e.ee   = (ecc_model({wc, di}) != eccb[5:0]) || (eccb[7:6] != 2'b00);
        e.lerr = over;
      end else if (lng && i >= 4 && i < 4 + int'(wc)) begin
        e.pv = 1'b1;
        e.pd = b[i];
        e.pl = (i == 3 + int'(wc));
      end else if (lng && i == 5 + int'(wc)) begin
        e.ok = ({b[i], b[i-1]} == crc);
        e.er = !e.ok;
      end
      tick(1'b1, 1'b1, b[i], e);
    end
    if (!skip_eot) begin
      e = idle_e();
      e.lerr = (n <= pend);
      tick(1'b0, 1'($urandom), 8'($urandom), e);
      repeat (2) tick(1'b0, 1'($urandom), 8'($urandom), idle_e());
    end
  endtask

  task automatic build(input logic [7:0] di, input logic [15:0] wc, input bit bad_ecc,
                       input bit bad_crc, input int ntrail, output bq_t q);
    logic [7:0]  eccb;
    logic [15:0] crc;
    bq_t         pay;
    q = {};
    q.push_back(di);
    q.push_back(wc[7:0]);
    q.push_back(wc[15:8]);
    eccb = {2'b00, ecc_model({wc, di})};
    if (bad_ecc) eccb ^= 8'(1 << $urandom_range(7));
    q.push_back(eccb);
    if (di[5:0] > 6'h0F && int'(wc) <= MAXW) begin
      pay = {};
      for (int i = 0; i < int'(wc); i++) pay.push_back(8'($urandom));
      crc = crc_model(pay);
      if (bad_crc) crc ^= 16'(1 << $urandom_range(15));
      foreach (pay[i]) q.push_back(pay[i]);
      q.push_back(crc[7:0]);
      q.push_back(crc[15:8]);
    end
    for (int i = 0; i < ntrail; i++) q.push_back(8'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn     = 1'b0;
    chk_en   = 1'b0;
    hs_mode  = 1'b0;
    byte_en  = 1'b0;
    hold_di  = 8'h00;
    hold_wc  = 16'h0000;
    exp_next = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({hdr_valid, pkt_di, pkt_wc, short_pkt, fs, fe, ls, le, pay_valid,
                              pay_data, pay_last, crc_ok, crc_err, ecc_err, len_err}), 64'd0);
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t         raw8, q;
    logic [7:0]  di;
    logic [15:0] wc;
    int          pend_len, n;
    for (int k = 0; k < 9; k++) begin cnt[k] = 0; base[k] = 0; end

    raw8 = {8'h2A, 8'h18, 8'h00, 8'h13,
            8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
            8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
            8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01,
            8'hF0, 8'h00};

    // Pin the reference model against known-good header and payload values
    q = raw8[4:27];
    chk("model_crc_vector", 64'(crc_model(q)), 64'h00F0);
    chk("model_ecc_fs", 64'(ecc_model(24'h000100)), 64'h1A);
    chk("model_ecc_raw8", 64'(ecc_model(24'h00182A)), 64'h13);

    do_reset();

    // FS short packet
    snap();
    send_pkt('{8'h00, 8'h01, 8'h00, 8'h1A}, 4, 0, 1'b0);
    @(negedge clk); #1;
    chk("fs_hdr_valid", 64'(dlt(C_HV)), 64'd1);
    chk("fs_short", 64'(dlt(C_SP)), 64'd1);
    chk("fs_pulse", 64'(dlt(C_FS)), 64'd1);
    chk("fs_wc", 64'(pkt_wc), 64'h0001);
    chk("fs_ecc_err", 64'(dlt(C_EE)), 64'd0);
    chk("fs_no_payload", 64'(dlt(C_PV)), 64'd0);

    // RAW8 long packet, good CRC
    snap();
    send_pkt(raw8, raw8.size(), 0, 1'b0);
    @(negedge clk); #1;
    chk("raw8_pay_count", 64'(dlt(C_PV)), 64'd24);
    chk("raw8_last_count", 64'(dlt(C_PL)), 64'd1);
    chk("raw8_last_data", 64'(last_pl_data), 64'h01);
    chk("raw8_crc_ok", 64'(dlt(C_OK)), 64'd1);

    // Same packet, corrupted CRC
    q = raw8;
    q[28] = 8'hF1;
    snap();
    send_pkt(q, q.size(), 30, 1'b0);
    @(negedge clk); #1;
    chk("badcrc_err", 64'(dlt(C_ERR)), 64'd1);
    chk("badcrc_ok", 64'(dlt(C_OK)), 64'd0);

    // Header ECC bit flipped
    snap();
    send_pkt('{8'h00, 8'h01, 8'h00, 8'h1B}, 4, 0, 1'b0);
    @(negedge clk); #1;
    chk("ecc_flip_err", 64'(dlt(C_EE)), 64'd1);
    chk("ecc_flip_fs", 64'(dlt(C_FS)), 64'd1);

    // Oversize word count, trailing bytes discarded
    snap();
    send_pkt('{8'h2A, 8'h01, 8'h20, 8'h55, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 8, 0, 1'b0);
    @(negedge clk); #1;
    chk("oversize_len_err", 64'(dlt(C_LEN)), 64'd1);
    chk("oversize_no_pay", 64'(dlt(C_PV)), 64'd0);

    // Early EoT after 10 payload bytes, then an FS packet
    snap();
    send_pkt(raw8, 14, 0, 1'b0);
    @(negedge clk); #1;
    chk("eot_pay_count", 64'(dlt(C_PV)), 64'd10);
    chk("eot_no_last", 64'(dlt(C_PL)), 64'd0);
    chk("eot_len_err", 64'(dlt(C_LEN)), 64'd1);
    snap();
    send_pkt('{8'h00, 8'h01, 8'h00, 8'h1A}, 4, 0, 1'b0);
    @(negedge clk); #1;
    chk("after_eot_fs", 64'(dlt(C_FS)), 64'd1);
    chk("after_eot_ecc", 64'(dlt(C_EE)), 64'd0);

    // Word count boundaries: MAX_WC accepted, MAX_WC+1 rejected, zero-length long packet
    build(8'h2B, 16'd4096, 1'b0, 1'b0, 0, q);
    snap();
    send_pkt(q, q.size(), 0, 1'b0);
    @(negedge clk); #1;
    chk("maxwc_pay_count", 64'(dlt(C_PV)), 64'd4096);
    chk("maxwc_no_len_err", 64'(dlt(C_LEN)), 64'd0);
    chk("maxwc_crc_ok", 64'(dlt(C_OK)), 64'd1);
    build(8'h2B, 16'd4097, 1'b0, 1'b0, 3, q);
    snap();
    send_pkt(q, q.size(), 0, 1'b0);
    @(negedge clk); #1;
    chk("maxwc1_len_err", 64'(dlt(C_LEN)), 64'd1);
    chk("maxwc1_no_pay", 64'(dlt(C_PV)), 64'd0);
    build(8'h12, 16'd0, 1'b0, 1'b0, 0, q);
    snap();
    send_pkt(q, q.size(), 0, 1'b0);
    @(negedge clk); #1;
    chk("wc0_crc_ok", 64'(dlt(C_OK)), 64'd1);

    // Reset in the middle of a payload, then a clean FS packet
    build(8'h2A, 16'd20, 1'b0, 1'b0, 0, q);
    send_pkt(q, 10, 0, 1'b1);
    do_reset();
    snap();
    send_pkt('{8'h00, 8'h01, 8'h00, 8'h1A}, 4, 0, 1'b0);
    @(negedge clk); #1;
    chk("post_reset_fs", 64'(dlt(C_FS)), 64'd1);

    // Randomized packet mix
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(1) == 0) begin
        di = {2'($urandom), 6'($urandom_range(15))};
        wc = 16'($urandom);
        pend_len = 4;
      end else begin
        di = {2'($urandom), 6'($urandom_range(63, 16))};
        wc = ($urandom_range(9) == 0) ? 16'(4097 + $urandom_range(60000)) : 16'($urandom_range(40));
        pend_len = (int'(wc) > MAXW) ? 4 : 6 + int'(wc);
      end
      build(di, wc, $urandom_range(99) < 15, $urandom_range(99) < 20, $urandom_range(3), q);
      n = ($urandom_range(99) < 15) ? $urandom_range(pend_len - 1, 1) : q.size();
      send_pkt(q, n, 20, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
